// File: rtl/rom_port_arbiter_if.sv
// rtl/rom_port_arbiter_if.sv - requester and SDRAM ROM port signals for rom_port_arbiter
interface rom_port_arbiter_if;
    logic        cpu_req;
    logic        cpu_ack;
    logic [23:1] cpu_addr;
    logic        cpu_we;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;

    logic        cop_req;
    logic        cop_ack;
    logic [23:1] cop_addr;
    logic        cop_we;
    logic [15:0] cop_din;
    logic [15:0] cop_dout;

    logic        ld_req;
    logic        ld_ack;
    logic [23:1] ld_addr;
    logic        ld_we;
    logic [15:0] ld_din;
    logic [15:0] ld_dout;

    logic        mem_req;
    logic        mem_ack;
    logic [23:1] mem_addr;
    logic        mem_we;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_din,
        output cpu_ack, cpu_dout,
        input  cop_req, cop_addr, cop_we, cop_din,
        output cop_ack, cop_dout,
        input  ld_req, ld_addr, ld_we, ld_din,
        output ld_ack, ld_dout,
        output mem_req, mem_addr, mem_we, mem_din,
        input  mem_ack, mem_dout
    );

    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_din,
        input  cpu_ack, cpu_dout,
        output cop_req, cop_addr, cop_we, cop_din,
        input  cop_ack, cop_dout,
        output ld_req, ld_addr, ld_we, ld_din,
        input  ld_ack, ld_dout,
        input  mem_req, mem_addr, mem_we, mem_din,
        output mem_ack, mem_dout
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - three-way toggle-handshake arbiter onto one SDRAM ROM port
module rom_port_arbiter #(
    parameter int unsigned READ_DELAY = 4
) (
    input  logic              clk,
    input  logic              reset,
    rom_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DATA} state_e;
    typedef enum logic [1:0] {GNT_CPU, GNT_COP, GNT_LD} grantee_e;

    localparam logic [3:0] DELAY_LOAD = 4'(READ_DELAY);

    state_e      state_q;
    grantee_e    grantee_q;
    grantee_e    grant_d;
    logic        grant_valid_d;
    logic        cop_first_q;
    logic [3:0]  cnt_q;

    logic        cpu_ack_q, cop_ack_q, ld_ack_q;
    logic [15:0] cpu_dout_q, cop_dout_q, ld_dout_q;
    logic        mem_req_q, mem_we_q;
    logic [23:1] mem_addr_q;
    logic [15:0] mem_din_q;

    logic [23:1] addr_d;
    logic        we_d;
    logic [15:0] din_d;
    logic        cpu_pend, cop_pend, ld_pend;

    assign cpu_pend = bus.cpu_req != cpu_ack_q;
    assign cop_pend = bus.cop_req != cop_ack_q;
    assign ld_pend  = bus.ld_req  != ld_ack_q;

    // Loader always wins; CPU and coprocessor alternate when both are waiting.
    always_comb begin
        grant_valid_d = 1'b1;
        grant_d       = GNT_CPU;
        if (ld_pend) begin
            grant_d = GNT_LD;
        end else if (cpu_pend && cop_pend) begin
            grant_d = cop_first_q ? GNT_COP : GNT_CPU;
        end else if (cop_pend) begin
            grant_d = GNT_COP;
        end else if (!cpu_pend) begin
            grant_valid_d = 1'b0;
        end
    end

    always_comb begin
        addr_d = bus.cpu_addr;
        we_d   = bus.cpu_we;
        din_d  = bus.cpu_din;
        case (grant_d)
            GNT_COP: begin
                addr_d = bus.cop_addr;
                we_d   = bus.cop_we;
                din_d  = bus.cop_din;
            end
            GNT_LD: begin
                addr_d = bus.ld_addr;
                we_d   = bus.ld_we;
                din_d  = bus.ld_din;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grantee_q   <= GNT_CPU;
            cop_first_q <= 1'b0;
            cnt_q       <= 4'd0;
            cpu_ack_q   <= 1'b0;
            cop_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            cpu_dout_q  <= 16'd0;
            cop_dout_q  <= 16'd0;
            ld_dout_q   <= 16'd0;
            // Matching the current ack means no request is left outstanding downstream.
            mem_req_q   <= bus.mem_ack;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid_d) begin
                        grantee_q  <= grant_d;
                        mem_addr_q <= addr_d;
                        mem_we_q   <= we_d;
                        mem_din_q  <= din_d;
                        if (grant_d == GNT_CPU) begin
                            cop_first_q <= 1'b1;
                        end else if (grant_d == GNT_COP) begin
                            cop_first_q <= 1'b0;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_req_q <= ~mem_req_q;
                    state_q   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.mem_ack == mem_req_q) begin
                        if (mem_we_q) begin
                            case (grantee_q)
                                GNT_CPU: cpu_ack_q <= ~cpu_ack_q;
                                GNT_COP: cop_ack_q <= ~cop_ack_q;
                                default: ld_ack_q  <= ~ld_ack_q;
                            endcase
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= DELAY_LOAD;
                            state_q <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    // Final count step: the edge that would reach zero delivers the data.
                    if (cnt_q == 4'd1) begin
                        cnt_q <= 4'd0;
                        case (grantee_q)
                            GNT_CPU: begin
                                cpu_dout_q <= bus.mem_dout;
                                cpu_ack_q  <= ~cpu_ack_q;
                            end
                            GNT_COP: begin
                                cop_dout_q <= bus.mem_dout;
                                cop_ack_q  <= ~cop_ack_q;
                            end
                            default: begin
                                ld_dout_q <= bus.mem_dout;
                                ld_ack_q  <= ~ld_ack_q;
                            end
                        endcase
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.cop_ack  = cop_ack_q;
    assign bus.ld_ack   = ld_ack_q;
    assign bus.cpu_dout = cpu_dout_q;
    assign bus.cop_dout = cop_dout_q;
    assign bus.ld_dout  = ld_dout_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_din  = mem_din_q;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - self-checking bench for rom_port_arbiter
module tb_rom_port_arbiter;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rom_port_arbiter_if bus ();

    rom_port_arbiter #(.READ_DELAY(RD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_lat = -1;
    int match_cyc = 0;
    logic ovr_en = 1'b0;
    logic [15:0] ovr_val = 16'd0;

    logic        m_ack [3];
    logic [15:0] m_dout [3];
    bit          m_cop_first;
    logic        prev_req;

    logic [23:1] ra [3];
    logic        rw [3];
    logic [15:0] rdin [3];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom_word(logic [23:1] a);
        return (a[16:1] * 16'd40503) ^ {9'd0, a[23:17]} ^ 16'hC3A5;
    endfunction

    assign bus.mem_dout = ovr_en ? ovr_val : rom_word(bus.mem_addr);

    // SDRAM side: answers each new request after resp_lat cycles (random when negative).
    initial begin
        bus.mem_ack = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && bus.mem_req !== bus.mem_ack) begin
                int l;
                l = (resp_lat >= 0) ? resp_lat : int'($urandom_range(0, 4));
                repeat (l) @(negedge clk);
                bus.mem_ack = ~bus.mem_ack;
                match_cyc = cyc;
            end
        end
    end

    function automatic logic get_ack(int w);
        case (w)
            0:       return bus.cpu_ack;
            1:       return bus.cop_ack;
            default: return bus.ld_ack;
        endcase
    endfunction

    function automatic logic [15:0] get_dout(int w);
        case (w)
            0:       return bus.cpu_dout;
            1:       return bus.cop_dout;
            default: return bus.ld_dout;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_req(int w, logic [23:1] a, logic we, logic [15:0] d);
        case (w)
            0: begin bus.cpu_addr = a; bus.cpu_we = we; bus.cpu_din = d; bus.cpu_req = ~bus.cpu_req; end
            1: begin bus.cop_addr = a; bus.cop_we = we; bus.cop_din = d; bus.cop_req = ~bus.cop_req; end
            default: begin bus.ld_addr = a; bus.ld_we = we; bus.ld_din = d; bus.ld_req = ~bus.ld_req; end
        endcase
    endtask

    task automatic wait_issue(logic [23:1] a, logic we, logic [15:0] d);
        int n = 0;
        while (bus.mem_req === prev_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("issue_timeout", 32'(n < 100), 1);
        prev_req = bus.mem_req;
        check("mem_addr", 32'(bus.mem_addr), 32'(a));
        check("mem_we", 32'(bus.mem_we), 32'(we));
        check("mem_din", 32'(bus.mem_din), 32'(d));
    endtask

    task automatic wait_done(int w, logic [23:1] a, logic we, logic [15:0] d, logic [15:0] rdata);
        int n = 0;
        while (get_ack(w) === m_ack[w] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(n < 100), 1);
        check("ack_latency", 32'(cyc - match_cyc), we ? 32'd1 : 32'(RD + 1));
        m_ack[w] = ~m_ack[w];
        if (!we) m_dout[w] = rdata;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ack%0d", i), 32'(get_ack(i)), 32'(m_ack[i]));
            check($sformatf("dout%0d", i), 32'(get_dout(i)), 32'(m_dout[i]));
        end
        check("addr_stable", 32'(bus.mem_addr), 32'(a));
        check("din_stable", 32'(bus.mem_din), 32'(d));
    endtask

    task automatic reset_checks();
        for (int i = 0; i < 3; i++) begin
            m_ack[i]  = 1'b0;
            m_dout[i] = 16'd0;
            check($sformatf("rst_ack%0d", i), 32'(get_ack(i)), 0);
            check($sformatf("rst_dout%0d", i), 32'(get_dout(i)), 0);
        end
        m_cop_first = 1'b0;
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_din", 32'(bus.mem_din), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_req", 32'(bus.mem_req), 32'(bus.mem_ack));
        prev_req = bus.mem_req;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        bus.cop_req = 1'b0;
        bus.ld_req  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        reset_checks();
    endtask

    task automatic idle_check(string tag);
        repeat (10) @(negedge clk);
        check(tag, 32'(bus.mem_req), 32'(prev_req));
    endtask

    // All requesters in mask go pending on the same cycle; expected order from priority rules.
    task automatic round(bit [2:0] mask);
        int order[$];
        for (int i = 0; i < 3; i++) begin
            ra[i]   = 23'($urandom);
            rw[i]   = 1'($urandom_range(0, 1));
            rdin[i] = 16'($urandom);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) if (mask[i]) put_req(i, ra[i], rw[i], rdin[i]);
        if (mask[2]) order.push_back(2);
        if (mask[0] && mask[1]) begin
            if (m_cop_first) begin order.push_back(1); order.push_back(0); end
            else begin order.push_back(0); order.push_back(1); end
        end else if (mask[0]) order.push_back(0);
        else if (mask[1]) order.push_back(1);
        foreach (order[k]) begin
            int w;
            w = order[k];
            if (w == 0) m_cop_first = 1'b1;
            if (w == 1) m_cop_first = 1'b0;
            wait_issue(ra[w], rw[w], rdin[w]);
            wait_done(w, ra[w], rw[w], rdin[w], rom_word(ra[w]));
        end
    endtask

    initial begin
        logic saved_ack;
        reset = 1'b1;
        bus.cpu_req = 0; bus.cpu_addr = 0; bus.cpu_we = 0; bus.cpu_din = 0;
        bus.cop_req = 0; bus.cop_addr = 0; bus.cop_we = 0; bus.cop_din = 0;
        bus.ld_req  = 0; bus.ld_addr  = 0; bus.ld_we  = 0; bus.ld_din  = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        reset_checks();
        check("rst_mem_req_is_one", 32'(bus.mem_req), 1);
        idle_check("idle_after_reset");

        // Single CPU read with fixed downstream latency and known data.
        resp_lat = 3;
        ovr_en = 1'b1;
        ovr_val = 16'hBEEF;
        @(negedge clk);
        put_req(0, 23'h000100, 1'b0, 16'h0000);
        wait_issue(23'h000100, 1'b0, 16'h0000);
        wait_done(0, 23'h000100, 1'b0, 16'h0000, 16'hBEEF);
        check("cpu_dout_beef", 32'(bus.cpu_dout), 32'h0000BEEF);
        ovr_en = 1'b0;

        // Loader write.
        @(negedge clk);
        put_req(2, 23'h123456, 1'b1, 16'hA55A);
        wait_issue(23'h123456, 1'b1, 16'hA55A);
        wait_done(2, 23'h123456, 1'b1, 16'hA55A, 16'h0000);
        check("ld_dout_zero", 32'(bus.ld_dout), 0);

        // Three-way contention from a fresh pointer, then CPU/cop again.
        do_reset();
        resp_lat = -1;
        round(3'b111);
        round(3'b011);
        round(3'b011);

        // Requester re-toggles while its read waits for the downstream ack.
        resp_lat = 3;
        @(negedge clk);
        put_req(0, 23'h0ABCDE, 1'b0, 16'h1111);
        wait_issue(23'h0ABCDE, 1'b0, 16'h1111);
        bus.cpu_req = ~bus.cpu_req;
        wait_done(0, 23'h0ABCDE, 1'b0, 16'h1111, rom_word(23'h0ABCDE));
        wait_issue(23'h0ABCDE, 1'b0, 16'h1111);
        wait_done(0, 23'h0ABCDE, 1'b0, 16'h1111, rom_word(23'h0ABCDE));
        idle_check("no_extra_grant");

        // Reset during WAIT_DATA abandons the read.
        resp_lat = 0;
        @(negedge clk);
        put_req(1, 23'h00F00D, 1'b0, 16'h2222);
        wait_issue(23'h00F00D, 1'b0, 16'h2222);
        @(negedge clk);
        saved_ack = bus.mem_ack;
        check("wd_matched", 32'(bus.mem_ack), 32'(bus.mem_req));
        do_reset();
        check("wd_rst_mem_req", 32'(bus.mem_req), 32'(saved_ack));
        idle_check("idle_after_wd_reset");

        // Random contention rounds.
        resp_lat = -1;
        for (int r = 0; r < 30; r++) round(3'($urandom_range(1, 7)));
        idle_check("idle_at_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
